// File: rtl/mdu_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mdu_issue_ctrl_pkg
// Shared definitions for the MDU issue controller: datapath widths, MDU
// operation codes, default MDU latency, the issue FSM state encoding and a
// helper that packs the CR0 field from the MDU flags.
// Optional feature macro used by the importing RTL: MDU_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package mdu_issue_ctrl_pkg;

  localparam int ARCH_WIDTH        = 32;
  localparam int MDUOp_WIDTH       = 3;
  localparam int MDU_D_WIDTH       = 4;
  localparam int MDU_CYCLE_DEFAULT = 4;

  localparam logic [MDUOp_WIDTH-1:0] MDUOp_NOP   = 3'd0;
  localparam logic [MDUOp_WIDTH-1:0] MDUOp_MULH  = 3'd1;
  localparam logic [MDUOp_WIDTH-1:0] MDUOp_MULHU = 3'd2;
  localparam logic [MDUOp_WIDTH-1:0] MDUOp_MULW  = 3'd3;
  localparam logic [MDUOp_WIDTH-1:0] MDUOp_DIVW  = 3'd4;
  localparam logic [MDUOp_WIDTH-1:0] MDUOp_DIVWU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  // The MDU flag bus is {OV, LT, GT, EQ}: vector bit 3 is OV, bit 0 is EQ.
  // CR0 is {LT, GT, EQ, SO}; SO is sticky-ORed with a fresh overflow when
  // the instruction records OV.
  function automatic logic [3:0] cr0_pack(input logic [MDU_D_WIDTH-1:0] d,
                                          input logic                   so,
                                          input logic                   oe);
    cr0_pack = {d[2], d[1], d[0], so | (oe & d[3])};
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl_watchdog.sv
// -----------------------------------------------------------------------------
// mdu_watchdog
// Cycle counter guarding the WAIT phase of the MDU handshake.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr_i        synchronous clear of the count
//   en_i         count this cycle
//   expire_o     high in the LIMIT-th consecutive enabled cycle
// Only instantiated when MDU_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module mdu_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count_q;

  // Count enabled cycles; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CW{1'b0}};
    end else if (clr_i) begin
      count_q <= {CW{1'b0}};
    end else if (en_i) begin
      count_q <= count_q + CW'(1);
    end else begin
      count_q <= count_q;
    end
  end

  // count_q counts completed cycles, so LIMIT-1 marks the last allowed one.
  assign expire_o = en_i & (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/mdu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_issue_ctrl
// Initiator side of the multiply/divide unit handshake. Accepts one MUL/DIV
// from EX, issues a one-cycle req with operands to the MDU, stalls the
// pipeline while the MDU works, captures C/D on ack and presents a one-cycle
// writeback with optional CR0 and XER[OV] updates.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, op, opA, opB        operation request from EX
//   rd, rc, oe, xer_so         destination / record controls / current SO
//   flush                      kill the current operation
//   mdu_req, mdu_A/B, mdu_Op   request to the MDU
//   mdu_C, mdu_D, mdu_ack      response from the MDU (ack idles high)
//   stall                      hold the pipeline
//   wb_valid, wb_data, wb_rd   writeback
//   cr0_we, cr0_data           CR0 update
//   ov_we, ov                  XER[OV] update
//   err                        watchdog timeout pulse
// Optional feature: MDU_TIMEOUT_EN enables the WAIT watchdog (TIMEOUT cycles).
// -----------------------------------------------------------------------------
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int MDU_CYCLE = MDU_CYCLE_DEFAULT,
  parameter int TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [MDUOp_WIDTH-1:0] op,
  input  logic [ARCH_WIDTH-1:0]  opA,
  input  logic [ARCH_WIDTH-1:0]  opB,
  input  logic [4:0]             rd,
  input  logic                   rc,
  input  logic                   oe,
  input  logic                   xer_so,
  input  logic                   flush,
  output logic                   mdu_req,
  output logic [ARCH_WIDTH-1:0]  mdu_A,
  output logic [ARCH_WIDTH-1:0]  mdu_B,
  output logic [MDUOp_WIDTH-1:0] mdu_Op,
  input  logic [ARCH_WIDTH-1:0]  mdu_C,
  input  logic [MDU_D_WIDTH-1:0] mdu_D,
  input  logic                   mdu_ack,
  output logic                   stall,
  output logic                   wb_valid,
  output logic [ARCH_WIDTH-1:0]  wb_data,
  output logic [4:0]             wb_rd,
  output logic                   cr0_we,
  output logic [3:0]             cr0_data,
  output logic                   ov_we,
  output logic                   ov,
  output logic                   err
);

  // Elaboration-time parameter sanity checks.
  if (MDU_CYCLE < 2) begin : g_bad_cycle
    $error("mdu_issue_ctrl: MDU_CYCLE must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mdu_issue_ctrl: TIMEOUT must be at least 1");
  end

  mdu_state_e             state_q;
  logic [MDUOp_WIDTH-1:0] op_q;
  logic [ARCH_WIDTH-1:0]  a_q;
  logic [ARCH_WIDTH-1:0]  b_q;
  logic [4:0]             rd_q;
  logic                   rc_q;
  logic                   oe_q;
  logic [ARCH_WIDTH-1:0]  c_q;
  logic [MDU_D_WIDTH-1:0] d_q;
  logic                   kill_q;
  logic                   mdu_req_q;
  logic                   err_q;

  logic accept_s;
  logic expire_s;
  logic done_s;
  logic live_s;

  assign accept_s = (state_q == ST_IDLE) & start & (op != MDUOp_NOP) & ~flush;

`ifdef MDU_TIMEOUT_EN
  mdu_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q != ST_WAIT),
    .en_i     ((state_q == ST_WAIT) & ~mdu_ack),
    .expire_o (expire_s)
  );
`else
  assign expire_s = 1'b0;
`endif

  // Issue FSM: state, captured request/response and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= MDUOp_NOP;
      a_q       <= {ARCH_WIDTH{1'b0}};
      b_q       <= {ARCH_WIDTH{1'b0}};
      rd_q      <= 5'd0;
      rc_q      <= 1'b0;
      oe_q      <= 1'b0;
      c_q       <= {ARCH_WIDTH{1'b0}};
      d_q       <= {MDU_D_WIDTH{1'b0}};
      kill_q    <= 1'b0;
      mdu_req_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      mdu_req_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            op_q      <= op;
            a_q       <= opA;
            b_q       <= opB;
            rd_q      <= rd;
            rc_q      <= rc;
            oe_q      <= oe;
            kill_q    <= 1'b0;
            mdu_req_q <= 1'b1;
            state_q   <= ST_REQ;
          end else begin
            state_q   <= ST_IDLE;
          end
        end
        ST_REQ: begin
          // The MDU cannot be aborted: a flush only marks the result dead.
          if (flush) begin
            kill_q <= 1'b1;
          end else begin
            kill_q <= kill_q;
          end
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (flush) begin
            kill_q <= 1'b1;
          end else begin
            kill_q <= kill_q;
          end
          // The MDU result is only valid in the ack cycle.
          if (mdu_ack) begin
            c_q     <= mdu_C;
            d_q     <= mdu_D;
            state_q <= ST_DONE;
          end else if (expire_s) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_DONE: begin
          kill_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // A flush arriving in DONE itself still has to cancel the writeback.
  assign done_s   = (state_q == ST_DONE);
  assign live_s   = done_s & ~kill_q & ~flush;

  assign stall    = accept_s | (state_q == ST_REQ) | (state_q == ST_WAIT);
  assign mdu_req  = mdu_req_q;
  assign mdu_A    = a_q;
  assign mdu_B    = b_q;
  assign mdu_Op   = op_q;
  assign wb_valid = live_s;
  assign wb_data  = c_q;
  assign wb_rd    = rd_q;
  assign cr0_we   = live_s & rc_q;
  assign cr0_data = done_s ? cr0_pack(d_q, xer_so, oe_q) : 4'b0000;
  assign ov_we    = live_s & oe_q;
  assign ov       = d_q[3];
  assign err      = err_q;

endmodule
